// File: rtl/vga_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vga_arb_pkg
// Shared types and defaults for the VGA pixel-write arbiter.
//   state_e      : arbiter FSM states (idle, granted burst, one-cycle gap)
//   *_DEF        : default requester count, pixel widths and timeout
//   idx_width()  : width of a requester index (at least one bit)
// -----------------------------------------------------------------------------
package vga_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    localparam int unsigned NUM_REQ_DEF = 6;
    localparam int unsigned X_W_DEF     = 8;
    localparam int unsigned Y_W_DEF     = 7;
    localparam int unsigned COLOR_W_DEF = 3;
    localparam int unsigned TIMEOUT_DEF = 64;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// vga_write_arbiter_if
// Bundle between the drawing datapaths (master) and the arbiter (slave).
//   req/px_valid/px_last : per-requester burst control, one bit each
//   px_x/px_y/px_color   : flattened pixel lanes, requester i at [i*W +: W]
//   grant                : one-hot (or zero) burst grant
//   vga_x/y/colour/plot  : registered write to the VGA adapter
//   busy/active_id/timeout_err : status
// -----------------------------------------------------------------------------
interface vga_write_arbiter_if
    import vga_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned X_W     = X_W_DEF,
    parameter int unsigned Y_W     = Y_W_DEF,
    parameter int unsigned COLOR_W = COLOR_W_DEF
);
    localparam int unsigned ID_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         px_valid;
    logic [NUM_REQ-1:0]         px_last;
    logic [NUM_REQ*X_W-1:0]     px_x;
    logic [NUM_REQ*Y_W-1:0]     px_y;
    logic [NUM_REQ*COLOR_W-1:0] px_color;

    logic [NUM_REQ-1:0]         grant;
    logic [X_W-1:0]             vga_x;
    logic [Y_W-1:0]             vga_y;
    logic [COLOR_W-1:0]         vga_colour;
    logic                       vga_plot;
    logic                       busy;
    logic [ID_W-1:0]            active_id;
    logic                       timeout_err;

    modport master (
        output req, px_valid, px_last, px_x, px_y, px_color,
        input  grant, vga_x, vga_y, vga_colour, vga_plot, busy, active_id, timeout_err
    );

    modport slave (
        input  req, px_valid, px_last, px_x, px_y, px_color,
        output grant, vga_x, vga_y, vga_colour, vga_plot, busy, active_id, timeout_err
    );

endinterface

// File: rtl/vga_write_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational winner selection for the arbiter.
//   req_i     : request vector
//   ptr_i     : round-robin start index
//   prio0_i   : when set, requester 0 wins whenever it requests
//   winner_o  : selected requester index (0 when nothing requests)
//   any_req_o : at least one request present
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int unsigned NUM_REQ = 6,
    parameter int unsigned ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               prio0_i,
    output logic [ID_W-1:0]    winner_o,
    output logic               any_req_o
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = '0;
        // Walk upward from the pointer, wrapping; first hit wins.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((32'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[idx]) begin
                winner_o = idx;
                found    = 1'b1;
            end
        end
        if (prio0_i && req_i[0]) begin
            winner_o = '0;
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/vga_write_arbiter.sv
// -----------------------------------------------------------------------------
// vga_write_arbiter
// Shares the single VGA adapter pixel-write port among NUM_REQ drawers with
// burst-locked round-robin grants (requester 0 optionally prioritised).
//   clk    : clock
//   resetn : synchronous active-low reset
//   bus    : vga_write_arbiter_if slave modport (requests, pixel lanes,
//            grant, registered adapter write, status)
// -----------------------------------------------------------------------------
module vga_write_arbiter
    import vga_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned X_W     = X_W_DEF,
    parameter int unsigned Y_W     = Y_W_DEF,
    parameter int unsigned COLOR_W = COLOR_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter bit          PRIO0   = 1'b1
) (
    input logic              clk,
    input logic              resetn,
    vga_write_arbiter_if.slave bus
);

    localparam int unsigned     ID_W    = idx_width(NUM_REQ);
    localparam int unsigned     CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_e               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [ID_W-1:0]      id_q;
    logic [ID_W-1:0]      ptr_q;
    logic [CNT_W-1:0]     idle_q;
    logic                 plot_q;
    logic                 terr_q;
    logic [X_W-1:0]       x_q;
    logic [Y_W-1:0]       y_q;
    logic [COLOR_W-1:0]   c_q;

    logic [ID_W-1:0]      winner;
    logic [ID_W-1:0]      next_ptr;
    logic                 any_req;
    logic [CNT_W-1:0]     idle_inc;

    logic                 own_valid;
    logic                 own_last;
    logic                 own_req;
    logic [X_W-1:0]       own_x;
    logic [Y_W-1:0]       own_y;
    logic [COLOR_W-1:0]   own_c;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req_i     (bus.req),
        .ptr_i     (ptr_q),
        .prio0_i   (PRIO0),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    // Lane of the current burst owner.
    assign own_valid = bus.px_valid[id_q];
    assign own_last  = bus.px_last[id_q];
    assign own_req   = bus.req[id_q];
    assign own_x     = bus.px_x[32'(id_q) * X_W +: X_W];
    assign own_y     = bus.px_y[32'(id_q) * Y_W +: Y_W];
    assign own_c     = bus.px_color[32'(id_q) * COLOR_W +: COLOR_W];

    assign next_ptr = (32'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    assign idle_inc = (idle_q == CNT_MAX) ? CNT_MAX : idle_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            idle_q  <= '0;
            plot_q  <= 1'b0;
            terr_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
        end else begin
            plot_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        state_q <= S_GRANT;
                        grant_q <= NUM_REQ'(1) << winner;
                        id_q    <= winner;
                        ptr_q   <= next_ptr;
                        idle_q  <= '0;
                    end
                end
                S_GRANT: begin
                    if (own_valid) begin
                        plot_q <= 1'b1;
                        x_q    <= own_x;
                        y_q    <= own_y;
                        c_q    <= own_c;
                        idle_q <= '0;
                    end else begin
                        idle_q <= idle_inc;
                    end
                    // A dropped request ends the burst even if it would also time out.
                    if ((own_valid && own_last) || !own_req) begin
                        state_q <= S_GAP;
                        grant_q <= '0;
                    end else if (!own_valid && idle_inc == CNT_MAX) begin
                        state_q <= S_GAP;
                        grant_q <= '0;
                        terr_q  <= 1'b1;
                    end
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.vga_x       = x_q;
    assign bus.vga_y       = y_q;
    assign bus.vga_colour  = c_q;
    assign bus.vga_plot    = plot_q;
    assign bus.busy        = (state_q == S_GRANT);
    assign bus.active_id   = id_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_write_arbiter
// Drives two arbiters (PRIO0=1 and PRIO0=0) with identical stimulus and checks
// them against a cycle model built from burst ownership, a gap countdown and a
// round-robin search, plus a vector table and directed corner sequences.
// -----------------------------------------------------------------------------
module tb_vga_write_arbiter;

    localparam int unsigned N  = 6;
    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned CW = 3;
    localparam int unsigned TO = 64;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req = '0;
    logic [N-1:0]    pv  = '0;
    logic [N-1:0]    pl  = '0;
    logic [N*XW-1:0] px  = '0;
    logic [N*YW-1:0] py  = '0;
    logic [N*CW-1:0] pc  = '0;

    vga_write_arbiter_if #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW)) bus0 ();
    vga_write_arbiter_if #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW)) bus1 ();

    assign bus0.req = req;  assign bus0.px_valid = pv;  assign bus0.px_last = pl;
    assign bus0.px_x = px;  assign bus0.px_y = py;      assign bus0.px_color = pc;
    assign bus1.req = req;  assign bus1.px_valid = pv;  assign bus1.px_last = pl;
    assign bus1.px_x = px;  assign bus1.px_y = py;      assign bus1.px_color = pc;

    vga_write_arbiter #(
        .NUM_REQ (N), .X_W (XW), .Y_W (YW), .COLOR_W (CW), .TIMEOUT (TO), .PRIO0 (1'b1)
    ) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0.slave)
    );

    vga_write_arbiter #(
        .NUM_REQ (N), .X_W (XW), .Y_W (YW), .COLOR_W (CW), .TIMEOUT (TO), .PRIO0 (1'b0)
    ) dut1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int           m_owner [2];   // -1 when nobody holds the port
    bit           m_gap   [2];   // one dead cycle pending after a burst
    int           m_ptr   [2];
    int           m_idle  [2];
    bit           e_plot  [2];
    logic [XW-1:0] e_x    [2];
    logic [YW-1:0] e_y    [2];
    logic [CW-1:0] e_c    [2];
    logic [2:0]   e_id    [2];
    bit           e_terr  [2];

    task automatic model_step(input int d, input bit prio);
        int w;
        if (!resetn) begin
            m_owner[d] = -1; m_gap[d] = 0; m_ptr[d] = 0; m_idle[d] = 0;
            e_plot[d] = 0; e_x[d] = '0; e_y[d] = '0; e_c[d] = '0; e_id[d] = '0; e_terr[d] = 0;
            return;
        end
        e_plot[d] = 0;
        if (m_owner[d] >= 0) begin
            w = m_owner[d];
            if (pv[w]) begin
                e_plot[d] = 1;
                e_x[d] = px[w*XW +: XW];
                e_y[d] = py[w*YW +: YW];
                e_c[d] = pc[w*CW +: CW];
                m_idle[d] = 0;
            end else begin
                m_idle[d]++;
            end
            if ((pv[w] && pl[w]) || !req[w]) begin
                m_owner[d] = -1; m_gap[d] = 1;
            end else if (m_idle[d] >= TO) begin
                m_owner[d] = -1; m_gap[d] = 1; e_terr[d] = 1;
            end
        end else if (m_gap[d]) begin
            m_gap[d] = 0;
        end else if (req != 0) begin
            w = -1;
            if (prio && req[0]) w = 0;
            else for (int k = 0; k < N; k++) if (w < 0 && req[(m_ptr[d] + k) % N]) w = (m_ptr[d] + k) % N;
            m_owner[d] = w;
            m_ptr[d] = (w + 1) % N;
            m_idle[d] = 0;
            e_id[d] = 3'(w);
        end
    endtask

    function automatic logic [N-1:0] exp_grant(input int d);
        logic [N-1:0] g = '0;
        if (m_owner[d] >= 0) g[m_owner[d]] = 1'b1;
        return g;
    endfunction

    task automatic check_model();
        logic [29:0] a0, a1, x0, x1;
        a0 = {bus0.grant, bus0.vga_plot, bus0.vga_x, bus0.vga_y, bus0.vga_colour,
              bus0.active_id, bus0.busy, bus0.timeout_err};
        a1 = {bus1.grant, bus1.vga_plot, bus1.vga_x, bus1.vga_y, bus1.vga_colour,
              bus1.active_id, bus1.busy, bus1.timeout_err};
        x0 = {exp_grant(0), e_plot[0], e_x[0], e_y[0], e_c[0], e_id[0], m_owner[0] >= 0, e_terr[0]};
        x1 = {exp_grant(1), e_plot[1], e_x[1], e_y[1], e_c[1], e_id[1], m_owner[1] >= 0, e_terr[1]};
        chk("model_prio1", 64'(a0), 64'(x0));
        chk("model_prio0", 64'(a1), 64'(x1));
    endtask

    // One clock: model consumes the inputs the DUT samples, outputs checked just after.
    task automatic tick();
        @(posedge clk);
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        resetn = 1'b0; req = '0; pv = '0; pl = '0;
        tick();
        resetn = 1'b1;
    endtask

    typedef struct {
        bit            rstn;
        logic [N-1:0]  req;
        logic [N-1:0]  pv;
        logic [N-1:0]  pl;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
        logic [N-1:0]  e_grant;
        bit            e_plot;
        logic [XW-1:0] e_x;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int n_seen, last_cyc, n_hi, n_plot;

        // Row i holds the inputs of cycle i and the outputs expected in cycle i+1.
        tbl[0] = '{1'b0, 6'b000000, 6'b000000, 6'b000000, 8'd0,  7'd0,  3'b000, 6'b000000, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 6'b000000, 6'b000000, 6'b000000, 8'd0,  7'd0,  3'b000, 6'b000000, 1'b0, 8'd0};
        tbl[2] = '{1'b1, 6'b000100, 6'b000000, 6'b000000, 8'd0,  7'd0,  3'b000, 6'b000100, 1'b0, 8'd0};
        tbl[3] = '{1'b1, 6'b000100, 6'b000100, 6'b000000, 8'd10, 7'd20, 3'b101, 6'b000100, 1'b1, 8'd10};
        tbl[4] = '{1'b1, 6'b000100, 6'b000100, 6'b000100, 8'd11, 7'd20, 3'b101, 6'b000000, 1'b1, 8'd11};
        tbl[5] = '{1'b1, 6'b000000, 6'b000000, 6'b000000, 8'd0,  7'd0,  3'b000, 6'b000000, 1'b0, 8'd11};
        tbl[6] = '{1'b1, 6'b000000, 6'b000000, 6'b000000, 8'd0,  7'd0,  3'b000, 6'b000000, 1'b0, 8'd11};

        for (int i = 0; i < 7; i++) begin
            resetn = tbl[i].rstn; req = tbl[i].req; pv = tbl[i].pv; pl = tbl[i].pl;
            px = {N{tbl[i].x}}; py = {N{tbl[i].y}}; pc = {N{tbl[i].c}};
            tick();
            chk("tbl_grant", bus0.grant, tbl[i].e_grant);
            chk("tbl_plot", bus0.vga_plot, tbl[i].e_plot);
            chk("tbl_x", bus0.vga_x, tbl[i].e_x);
        end

        // Round robin between requesters 1 and 3 with single-pixel bursts.
        do_reset();
        req = 6'b001010; pv = 6'b001010; pl = 6'b001010;
        n_seen = 0; last_cyc = -1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus0.grant != '0) begin
                if (n_seen < 4) chk("rr_order", bus0.grant, (n_seen % 2 == 0) ? 6'b000010 : 6'b001000);
                if (last_cyc >= 0) chk("rr_spacing", 64'(c - last_cyc), 64'd3);
                last_cyc = c; n_seen++;
            end
        end
        chk("rr_count", 64'(n_seen), 64'd4);

        // No preemption; afterwards priority vs round robin from pointer 4.
        do_reset();
        req = 6'b001000; tick();
        chk("pri_own3", bus0.grant, 6'b001000);
        req = 6'b011001; pv = 6'b011001; pl = '0; tick();
        chk("pri_nopreempt_p1", bus0.grant, 6'b001000);
        chk("pri_nopreempt_p0", bus1.grant, 6'b001000);
        pv = 6'b001000; pl = 6'b001000; tick();
        chk("pri_release", bus0.grant, 6'b000000);
        pv = '0; pl = '0; tick(); tick();
        chk("pri_prio0_on", bus0.grant, 6'b000001);
        chk("pri_prio0_off", bus1.grant, 6'b010000);

        // Timeout: requester 2 never sends a pixel while 3 waits.
        do_reset();
        req = 6'b000100; tick();
        chk("to_grant2", bus0.grant, 6'b000100);
        req = 6'b001100; n_hi = 1;
        for (int c = 0; c < 200 && bus0.grant == 6'b000100; c++) begin
            tick();
            if (bus0.grant == 6'b000100) n_hi++;
        end
        chk("to_len", 64'(n_hi), 64'(TO));
        chk("to_err", bus0.timeout_err, 1'b1);
        tick();
        chk("to_gap", bus0.grant, 6'b000000);
        tick();
        chk("to_next", bus0.grant, 6'b001000);
        chk("to_sticky", bus0.timeout_err, 1'b1);

        // Abort after three pixels; requester 5 pixels must be ignored.
        do_reset();
        req = 6'b000010; tick();
        n_plot = 0;
        for (int k = 0; k < 3; k++) begin
            pv = 6'b100010;
            px[1*XW +: XW] = 8'(8'h10 + k);
            px[5*XW +: XW] = 8'(8'h50 + k);
            tick();
            if (bus0.vga_plot) begin
                n_plot++;
                chk("abort_x", bus0.vga_x, 64'(8'h10 + k));
            end
        end
        req = '0; pv = 6'b100000; tick();
        if (bus0.vga_plot) n_plot++;
        chk("abort_gap_grant", bus0.grant, 6'b000000);
        chk("abort_gap_busy", bus0.busy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus0.vga_plot) n_plot++;
        end
        chk("abort_plots", 64'(n_plot), 64'd3);

        // Reset in the middle of a burst, then pointer back at 0.
        do_reset();
        req = 6'b010000; tick();
        pv = 6'b010000; px[4*XW +: XW] = 8'h77; tick();
        chk("rst_plot_before", bus0.vga_plot, 1'b1);
        resetn = 1'b0; tick();
        chk("rst_plot", bus0.vga_plot, 1'b0);
        chk("rst_grant", bus0.grant, 6'b000000);
        chk("rst_x", bus0.vga_x, 8'h00);
        resetn = 1'b1; req = 6'b100010; pv = '0; tick();
        chk("rst_ptr0", bus0.grant, 6'b000010);

        // Random traffic; alternate busy phases with sparse-pixel phases for timeouts.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit sparse;
            sparse = ((cyc / 500) % 2) == 1;
            resetn = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, sparse ? 255 : 7) == 0) req[i] = ~req[i];
            end
            if (sparse) pv = ($urandom_range(0, 63) == 0) ? N'($urandom) : '0;
            else        pv = N'($urandom);
            pl = pv & N'($urandom) & N'($urandom);
            px = (N*XW)'({$urandom, $urandom});
            py = (N*YW)'({$urandom, $urandom});
            pc = (N*CW)'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
